ex_issue: RTL and testbench

EX_ISSUE -- requirements
Module: ex_issue

---
 rtl/ex_issue_pkg.sv | 43 ++++
 rtl/ex_issue_fwd_sel.sv | 33 +++
 rtl/ex_issue.sv | 158 +++++++++++++++
 tb/tb_ex_issue.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_issue_pkg.sv
// +------------------------------------------------------------------+
// | ex_issue_pkg : ALU opcodes, issue state encoding, entry type      |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package ex_issue_pkg;

  localparam logic [2:0] C_ALU_ADD  = 3'd0;
  localparam logic [2:0] C_ALU_SLL  = 3'd1;
  localparam logic [2:0] C_ALU_SLT  = 3'd2;
  localparam logic [2:0] C_ALU_SLTU = 3'd3;
  localparam logic [2:0] C_ALU_XOR  = 3'd4;
  localparam logic [2:0] C_ALU_SRL  = 3'd5;
  localparam logic [2:0] C_ALU_OR   = 3'd6;
  localparam logic [2:0] C_ALU_AND  = 3'd7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } issue_state_t;

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [2:0]  op;
    logic        neg;
    logic        sra;
    logic        wb_en;
  } issue_entry_t;

  localparam issue_entry_t C_ENTRY_RESET = '{
    in1: 32'd0, in2: 32'd0, rs2: 32'd0, pc: 32'd0,
    rd: 5'd0, op: C_ALU_ADD, neg: 1'b0, sra: 1'b0, wb_en: 1'b0
  };

endpackage

`default_nettype wire

// File: rtl/ex_issue_fwd_sel.sv
// +------------------------------------------------------------------+
// | fwd_sel : picks MEM, then WB, then register value for one operand |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module fwd_sel (
  input  logic [4:0]  idx,
  input  logic [31:0] reg_val,
  input  logic        mem_en,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_val,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_val,
  output logic [31:0] val
);

  logic w_nonzero;
  logic w_mem_hit;
  logic w_wb_hit;

  // x0 is hard-wired zero and must never pick up a forwarded value
  assign w_nonzero = (idx != 5'd0);
  assign w_mem_hit = w_nonzero && mem_en && (mem_rd == idx);
  assign w_wb_hit  = w_nonzero && wb_en && (wb_rd == idx);

  assign val = w_mem_hit ? mem_val :
               w_wb_hit  ? wb_val  : reg_val;

endmodule

`default_nettype wire

// File: rtl/ex_issue.sv
// +------------------------------------------------------------------+
// | ex_issue : 2-entry skid buffer resolving operands for the ALU     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module ex_issue
  import ex_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_rs1_idx,
  input  logic [4:0]  in_rs2_idx,
  input  logic [4:0]  in_rd_idx,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  input  logic [31:0] in_imm,
  input  logic        in_use_pc,
  input  logic        in_use_imm,
  input  logic [2:0]  in_alu_op,
  input  logic        in_neg,
  input  logic        in_sra,
  input  logic        in_wb_en,
  input  logic        fwd_mem_en,
  input  logic [4:0]  fwd_mem_rd,
  input  logic [31:0] fwd_mem_val,
  input  logic        fwd_wb_en,
  input  logic [4:0]  fwd_wb_rd,
  input  logic [31:0] fwd_wb_val,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [2:0]  alu_op,
  output logic        alu_neg,
  output logic        alu_sra,
  output logic [31:0] out_rs2_val,
  output logic [31:0] out_pc,
  output logic [4:0]  out_rd,
  output logic        out_wb_en
);

  issue_state_t r_state;
  issue_entry_t r_main;
  issue_entry_t r_skid;
  issue_entry_t w_new;
  logic         r_out_valid;
  logic         r_in_ready;
  logic [31:0]  w_rs1;
  logic [31:0]  w_rs2;
  logic         w_accept;
  logic         w_emit;

  fwd_sel u_fwd_rs1 (
    .idx(in_rs1_idx), .reg_val(in_rs1_val),
    .mem_en(fwd_mem_en), .mem_rd(fwd_mem_rd), .mem_val(fwd_mem_val),
    .wb_en(fwd_wb_en), .wb_rd(fwd_wb_rd), .wb_val(fwd_wb_val),
    .val(w_rs1)
  );

  fwd_sel u_fwd_rs2 (
    .idx(in_rs2_idx), .reg_val(in_rs2_val),
    .mem_en(fwd_mem_en), .mem_rd(fwd_mem_rd), .mem_val(fwd_mem_val),
    .wb_en(fwd_wb_en), .wb_rd(fwd_wb_rd), .wb_val(fwd_wb_val),
    .val(w_rs2)
  );

  assign w_accept = in_valid && r_in_ready;
  assign w_emit   = r_out_valid && out_ready;

  always_comb begin
    w_new       = C_ENTRY_RESET;
    w_new.in1   = in_use_pc ? in_pc : w_rs1;
    w_new.in2   = in_use_imm ? in_imm : w_rs2;
    w_new.rs2   = w_rs2;
    w_new.pc    = in_pc;
    w_new.rd    = in_rd_idx;
    w_new.op    = in_alu_op;
    w_new.neg   = in_neg;
    w_new.sra   = in_sra;
    w_new.wb_en = in_wb_en;
  end

  // Clearing main.wb_en on every entry to EMPTY keeps out_wb_en low when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_main      <= C_ENTRY_RESET;
      r_skid      <= C_ENTRY_RESET;
    end else if (flush) begin
      r_state      <= ST_EMPTY;
      r_out_valid  <= 1'b0;
      r_in_ready   <= 1'b1;
      r_main.wb_en <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main      <= w_new;
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_emit) begin
            r_main <= w_new;
          end else if (w_accept) begin
            r_skid      <= w_new;
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b0;
          end else if (w_emit) begin
            r_state      <= ST_EMPTY;
            r_out_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
            r_main.wb_en <= 1'b0;
          end
        end
        ST_FULL: begin
          if (w_emit) begin
            r_main      <= r_skid;
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_EMPTY;
          r_out_valid  <= 1'b0;
          r_in_ready   <= 1'b1;
          r_main.wb_en <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign in_ready    = r_in_ready;
  assign alu_in1     = r_main.in1;
  assign alu_in2     = r_main.in2;
  assign alu_op      = r_main.op;
  assign alu_neg     = r_main.neg;
  assign alu_sra     = r_main.sra;
  assign out_rs2_val = r_main.rs2;
  assign out_pc      = r_main.pc;
  assign out_rd      = r_main.rd;
  assign out_wb_en   = r_main.wb_en;

endmodule

`default_nettype wire

// File: tb/tb_ex_issue.sv
// +------------------------------------------------------------------+
// | tb_ex_issue : directed + random bench against a queue model       |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_ex_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [4:0]  in_rs1_idx = '0, in_rs2_idx = '0, in_rd_idx = '0;
  logic [31:0] in_rs1_val = '0, in_rs2_val = '0, in_imm = '0;
  logic        in_use_pc = 1'b0, in_use_imm = 1'b0;
  logic [2:0]  in_alu_op = '0;
  logic        in_neg = 1'b0, in_sra = 1'b0, in_wb_en = 1'b0;
  logic        fwd_mem_en = 1'b0;
  logic [4:0]  fwd_mem_rd = '0;
  logic [31:0] fwd_mem_val = '0;
  logic        fwd_wb_en = 1'b0;
  logic [4:0]  fwd_wb_rd = '0;
  logic [31:0] fwd_wb_val = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] alu_in1, alu_in2, out_rs2_val, out_pc;
  logic [2:0]  alu_op;
  logic        alu_neg, alu_sra, out_wb_en;
  logic [4:0]  out_rd;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] in1, in2, rs2, pc;
    logic [4:0]  rd;
    logic [2:0]  op;
    logic        neg, sra, wb;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  ex_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
    .in_rd_idx(in_rd_idx), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_imm(in_imm), .in_use_pc(in_use_pc), .in_use_imm(in_use_imm),
    .in_alu_op(in_alu_op), .in_neg(in_neg), .in_sra(in_sra), .in_wb_en(in_wb_en),
    .fwd_mem_en(fwd_mem_en), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_val(fwd_mem_val),
    .fwd_wb_en(fwd_wb_en), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_val(fwd_wb_val),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_neg(alu_neg),
    .alu_sra(alu_sra), .out_rs2_val(out_rs2_val), .out_pc(out_pc),
    .out_rd(out_rd), .out_wb_en(out_wb_en)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rv);
    if (idx == 5'd0) return rv;
    if (fwd_mem_en && fwd_mem_rd == idx) return fwd_mem_val;
    if (fwd_wb_en && fwd_wb_rd == idx) return fwd_wb_val;
    return rv;
  endfunction

  function automatic exp_t incoming();
    exp_t e;
    e.rs2 = operand(in_rs2_idx, in_rs2_val);
    e.in1 = in_use_pc ? in_pc : operand(in_rs1_idx, in_rs1_val);
    e.in2 = in_use_imm ? in_imm : e.rs2;
    e.pc  = in_pc;
    e.rd  = in_rd_idx;
    e.op  = in_alu_op;
    e.neg = in_neg;
    e.sra = in_sra;
    e.wb  = in_wb_en;
    return e;
  endfunction

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      check("alu_in1", alu_in1, q[0].in1);
      check("alu_in2", alu_in2, q[0].in2);
      check("rs2_val", out_rs2_val, q[0].rs2);
      check("out_pc", out_pc, q[0].pc);
      check("out_rd", 32'(out_rd), 32'(q[0].rd));
      check("alu_op", 32'(alu_op), 32'(q[0].op));
      check("alu_neg", 32'(alu_neg), 32'(q[0].neg));
      check("alu_sra", 32'(alu_sra), 32'(q[0].sra));
      check("wb_en", 32'(out_wb_en), 32'(q[0].wb));
    end else begin
      check("idle_wb_en", 32'(out_wb_en), 32'd0);
    end
  endtask

  task automatic check_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_op", 32'(alu_op), 32'd0);
    check("rst_in1", alu_in1, 32'd0);
    check("rst_in2", alu_in2, 32'd0);
    check("rst_rs2", out_rs2_val, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_misc", {24'd0, out_rd, alu_neg, alu_sra, out_wb_en}, 32'd0);
  endtask

  // One clock: predict from current inputs, step the model, compare
  task automatic tick();
    exp_t e;
    bit acc, emt, was_rst;
    e = incoming();
    was_rst = rst;
    acc = in_valid && (q.size() < 2);
    emt = (q.size() > 0) && out_ready;
    @(posedge clk);
    #1;
    if (rst || flush) q.delete();
    else begin
      if (emt) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    check_outputs();
    if (was_rst) check_reset();
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; out_ready = 1; rst = 0;
    in_rs1_idx = 0; in_rs2_idx = 0; in_rd_idx = 0;
    in_use_pc = 0; in_use_imm = 0; in_alu_op = 0;
    fwd_mem_en = 0; fwd_wb_en = 0; fwd_mem_rd = 0; fwd_wb_rd = 0;
  endtask

  task automatic push_two_blocked();
    out_ready = 0; in_valid = 1;
    in_rs1_val = 32'hA; tick();
    in_rs1_val = 32'hB; tick();
  endtask

  initial begin
    rst = 1; tick();
    idle();

    // basic
    in_valid = 1; in_rs1_idx = 1; in_rs2_idx = 2;
    in_rs1_val = 5; in_rs2_val = 7; in_alu_op = 3'd0; in_wb_en = 1; in_rd_idx = 9;
    tick();
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_in1", alu_in1, 32'd5);
    check("basic_in2", alu_in2, 32'd7);
    idle(); tick();

    // forwarding priority and x0
    in_valid = 1; in_rs1_idx = 3; in_rs1_val = 32'h33;
    fwd_mem_en = 1; fwd_mem_rd = 3; fwd_mem_val = 32'hAA;
    fwd_wb_en = 1; fwd_wb_rd = 3; fwd_wb_val = 32'hBB;
    tick();
    check("fwd_mem_prio", alu_in1, 32'hAA);
    in_rs1_idx = 0; fwd_mem_rd = 0; fwd_wb_rd = 0; in_rs1_val = 32'h44;
    tick();
    check("fwd_x0", alu_in1, 32'h44);

    // immediate and pc select
    in_use_imm = 1; in_imm = 32'hFFFFFFFC; in_rs2_idx = 4; in_rs2_val = 32'h99;
    fwd_mem_rd = 4; fwd_mem_val = 32'h11;
    tick();
    check("imm_in2", alu_in2, 32'hFFFFFFFC);
    check("imm_rs2", out_rs2_val, 32'h11);
    in_use_imm = 0; in_use_pc = 1; in_pc = 32'h100;
    tick();
    check("pc_in1", alu_in1, 32'h100);
    idle(); tick();

    // backpressure
    push_two_blocked();
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_hold_a", alu_in1, 32'hA);
    in_valid = 0; tick();
    check("bp_hold_a2", alu_in1, 32'hA);
    out_ready = 1; tick();
    check("bp_emit_b", alu_in1, 32'hB);
    check("bp_ready_back", 32'(in_ready), 32'd1);
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // flush from FULL with incoming entry
    push_two_blocked();
    in_valid = 1; flush = 1; in_rs1_val = 32'hC; tick();
    check("flush_empty", 32'(out_valid), 32'd0);
    flush = 0; in_valid = 0; tick();
    check("flush_no_new", 32'(out_valid), 32'd0);

    // reset mid-FULL
    push_two_blocked();
    rst = 1; in_valid = 1; tick();
    idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 31) == 0);
      rst         = ($urandom_range(0, 99) == 0);
      in_pc       = $urandom;
      in_rs1_idx  = 5'($urandom_range(0, 3));
      in_rs2_idx  = 5'($urandom_range(0, 3));
      in_rd_idx   = 5'($urandom);
      in_rs1_val  = $urandom;
      in_rs2_val  = $urandom;
      in_imm      = $urandom;
      in_use_pc   = 1'($urandom);
      in_use_imm  = 1'($urandom);
      in_alu_op   = 3'($urandom);
      in_neg      = 1'($urandom);
      in_sra      = 1'($urandom);
      in_wb_en    = 1'($urandom);
      fwd_mem_en  = 1'($urandom);
      fwd_mem_rd  = 5'($urandom_range(0, 3));
      fwd_mem_val = $urandom;
      fwd_wb_en   = 1'($urandom);
      fwd_wb_rd   = 5'($urandom_range(0, 3));
      fwd_wb_val  = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
